instr_aligner: RTL and testbench

- Fetch-side halfword realignment buffer for the RV32IC core.
- Sits between instruction memory (32-bit word-aligned fetch stream) and the compressed decoder.
- Splits each fetched word into 16-bit parcels, reassembles 32-bit instructions that straddle word boundaries, and presents one instruction per handshake with its PC.
- Tracks PC redirects (flush), including redirect targets on odd halfword boundaries.

---
 rtl/instr_aligner_pkg.sv | 27 ++
 rtl/instr_aligner_hw_queue.sv | 74 +++++++
 rtl/instr_aligner.sv | 94 +++++++++
 tb/tb_instr_aligner.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_aligner_pkg.sv
// instr_aligner_pkg
// Shared fetch-side definitions. The compressed decoder uses them too.
//   OPC_UNCOMPRESSED : opcode[1:0] value that marks a 32-bit instruction
//   hw_cnt_t         : halfword queue occupancy, 0..4
//   push_e           : number of parcels appended in one cycle
//   is_compressed()  : true when a parcel starts a 16-bit instruction
package instr_aligner_pkg;

  localparam logic [1:0]  OPC_UNCOMPRESSED = 2'b11;
  localparam int unsigned HW_CNT_W         = 3;
  localparam int unsigned HQ_DEPTH         = 4;

  typedef logic [HW_CNT_W-1:0] hw_cnt_t;
  typedef logic [15:0]         parcel_t;

  typedef enum logic [1:0] {
    PUSH_NONE = 2'd0,
    PUSH_ONE  = 2'd1,
    PUSH_TWO  = 2'd2
  } push_e;

  // An all-zero parcel also reports compressed. Rejecting it is the decoder's job.
  function automatic logic is_compressed(input parcel_t p);
    return p[1:0] != OPC_UNCOMPRESSED;
  endfunction

endpackage

// File: rtl/instr_aligner_hw_queue.sv
// instr_aligner_hw_queue
// hw_queue: a 4 x 16-bit shift queue of instruction parcels. Entry 0 is the head.
//   clk_i, rst_ni    : clock, async active-low reset
//   clear_i          : drop all entries (redirect); overrides push/pop
//   push_i           : PUSH_ONE appends push_hi_i; PUSH_TWO appends push_lo_i then push_hi_i
//   push_lo_i/hi_i   : parcel data to append
//   pop_i            : parcels removed from the head this cycle (0..2)
//   hq0_o, hq1_o     : the two head entries
//   count_o          : occupancy
// The caller must not overflow the queue. The top only pushes while count <= 2.
module instr_aligner_hw_queue
  import instr_aligner_pkg::*;
(
  input  logic    clk_i,
  input  logic    rst_ni,
  input  logic    clear_i,
  input  push_e   push_i,
  input  parcel_t push_lo_i,
  input  parcel_t push_hi_i,
  input  logic [1:0] pop_i,
  output parcel_t hq0_o,
  output parcel_t hq1_o,
  output hw_cnt_t count_o
);

  parcel_t     q_q [HQ_DEPTH];
  parcel_t     q_d [HQ_DEPTH];
  hw_cnt_t     count_q, count_d;
  int unsigned pop_n;
  int unsigned base;

  // Pop first by shifting toward the head. Then append at the first free slot
  // that remains after the pop. A pop and a push in the same cycle compose this way.
  always_comb begin
    pop_n   = {30'b0, pop_i};
    base    = {29'b0, count_q} - pop_n;
    count_d = count_q - hw_cnt_t'(pop_i);
    for (int unsigned i = 0; i < HQ_DEPTH; i++) begin
      q_d[i] = '0;
      for (int unsigned j = 0; j < HQ_DEPTH; j++) begin
        if (j == i + pop_n) q_d[i] = q_q[j];
      end
    end
    for (int unsigned i = 0; i < HQ_DEPTH; i++) begin
      if (push_i == PUSH_TWO) begin
        if (i == base)     q_d[i] = push_lo_i;
        if (i == base + 1) q_d[i] = push_hi_i;
      end else if (push_i == PUSH_ONE) begin
        if (i == base)     q_d[i] = push_hi_i;
      end
    end
    if (push_i == PUSH_TWO)      count_d = count_d + hw_cnt_t'(2);
    else if (push_i == PUSH_ONE) count_d = count_d + hw_cnt_t'(1);
    if (clear_i) begin
      for (int unsigned i = 0; i < HQ_DEPTH; i++) q_d[i] = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < HQ_DEPTH; i++) q_q[i] <= '0;
      count_q <= '0;
    end else begin
      for (int unsigned i = 0; i < HQ_DEPTH; i++) q_q[i] <= q_d[i];
      count_q <= count_d;
    end
  end

  assign hq0_o   = q_q[0];
  assign hq1_o   = q_q[1];
  assign count_o = count_q;

endmodule

// File: rtl/instr_aligner.sv
// instr_aligner
// Fetch-side halfword realignment buffer for RV32IC. It takes 32-bit word-aligned
// fetch words, splits them into parcels, rebuilds instructions that straddle word
// boundaries, and presents one instruction per handshake together with its PC.
//   clk, reset (async, active-low)
//   in_valid/in_ready/in_data       : fetch word stream; in_data[15:0] is the lower address
//   out_valid/out_ready             : instruction handshake toward the decoder
//   out_instr, out_is_compressed, out_pc : head instruction; a compressed one is zero-extended
//   flush, flush_pc                 : redirect, highest priority; flush_pc bit 0 is ignored
module instr_aligner
  import instr_aligner_pkg::*;
#(
  parameter int unsigned      XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic            out_is_compressed,
  output logic [XLEN-1:0] out_pc,
  input  logic            flush,
  input  logic [XLEN-1:0] flush_pc
);

  logic [XLEN-1:0] head_pc_q, head_pc_d;
  logic            drop_half_q, drop_half_d;

  parcel_t    hq0, hq1;
  hw_cnt_t    count;
  logic       head_c;
  logic       push_acc, pop_fire;
  push_e      push_sel;
  logic [1:0] pop_sel;

  instr_aligner_hw_queue u_hw_queue (
    .clk_i     (clk),
    .rst_ni    (reset),
    .clear_i   (flush),
    .push_i    (push_sel),
    .push_lo_i (in_data[15:0]),
    .push_hi_i (in_data[31:16]),
    .pop_i     (pop_sel),
    .hq0_o     (hq0),
    .hq1_o     (hq1),
    .count_o   (count)
  );

  // in_ready depends only on the registered count. This keeps out_ready and
  // in_valid off the ready path.
  assign in_ready = (count <= hw_cnt_t'(2));
  assign head_c   = is_compressed(hq0);

  always_comb begin
    out_valid         = ((count >= hw_cnt_t'(1)) && head_c) || (count >= hw_cnt_t'(2));
    out_is_compressed = (count != '0) && head_c;
    out_instr         = head_c ? {16'h0, hq0} : {hq1, hq0};
    out_pc            = head_pc_q;

    push_acc = in_valid && in_ready && !flush;
    pop_fire = out_valid && out_ready && !flush;

    push_sel = PUSH_NONE;
    if (push_acc) push_sel = drop_half_q ? PUSH_ONE : PUSH_TWO;
    pop_sel = 2'd0;
    if (pop_fire) pop_sel = head_c ? 2'd1 : 2'd2;

    head_pc_d   = head_pc_q;
    drop_half_d = drop_half_q;
    if (flush) begin
      // A redirect to an odd halfword still fetches the enclosing word, so its lower half is skipped.
      head_pc_d   = flush_pc & ~XLEN'(1);
      drop_half_d = flush_pc[1];
    end else begin
      if (pop_fire) head_pc_d = head_pc_q + (head_c ? XLEN'(2) : XLEN'(4));
      if (push_acc) drop_half_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_pc_q   <= RESET_PC;
      drop_half_q <= RESET_PC[1];
    end else begin
      head_pc_q   <= head_pc_d;
      drop_half_q <= drop_half_d;
    end
  end

endmodule

// File: tb/tb_instr_aligner.sv
// tb_instr_aligner: directed self-checking bench for instr_aligner.
module tb_instr_aligner;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic        out_is_compressed;
  logic [31:0] out_pc;
  logic        flush = 1'b0;
  logic [31:0] flush_pc = '0;

  int nvec  = 0;
  int nfail = 0;

  logic [31:0] mon_instr [$];
  logic [31:0] mon_pc    [$];
  logic        mon_c     [$];

  instr_aligner #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk               (clk),
    .reset             (reset),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_data           (in_data),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_instr         (out_instr),
    .out_is_compressed (out_is_compressed),
    .out_pc            (out_pc),
    .flush             (flush),
    .flush_pc          (flush_pc)
  );

  always #5 clk = ~clk;

  // Log every instruction handshake the decoder side would see.
  always @(posedge clk) begin
    if (reset && out_valid && out_ready && !flush) begin
      mon_instr.push_back(out_instr);
      mon_pc.push_back(out_pc);
      mon_c.push_back(out_is_compressed);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    mon_instr.delete();
    mon_pc.delete();
    mon_c.delete();
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    reset     = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
    clear_mon();
  endtask

  task automatic send_word(input logic [31:0] w);
    int n = 0;
    in_valid = 1'b1;
    in_data  = w;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    nvec++;
    if (in_ready !== 1'b1) begin
      nfail++;
      $display("FAIL send_timeout word=%h in_ready=%b required 1", w, in_ready);
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h0000_0013;
    out_ready = 1'b0;
    step();
    step();
    nvec++; if (in_ready !== 1'b1) begin nfail++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
    nvec++; if (out_valid !== 1'b0) begin nfail++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    nvec++; if (out_pc !== 32'h0) begin nfail++; $display("FAIL rst_out_pc got %h want 0", out_pc); end
    nvec++; if (out_instr !== 32'h0) begin nfail++; $display("FAIL rst_out_instr got %h want 0", out_instr); end
    nvec++; if (out_is_compressed !== 1'b0) begin nfail++; $display("FAIL rst_out_is_c got %b want 0", out_is_compressed); end
    reset = 1'b1;
    step();
    in_valid = 1'b0;
    nvec++; if (out_valid !== 1'b1) begin nfail++; $display("FAIL rst_first_valid got %b want 1", out_valid); end
    nvec++; if (out_instr !== 32'h0000_0013) begin nfail++; $display("FAIL rst_first_instr got %h want 00000013", out_instr); end
    nvec++; if (out_pc !== 32'h0) begin nfail++; $display("FAIL rst_first_pc got %h want 0", out_pc); end
  endtask

  task automatic test_aligned();
    logic [31:0] ei [2] = '{32'h0000_0013, 32'h00A0_0093};
    logic [31:0] ep [2] = '{32'h0, 32'h4};
    do_reset();
    out_ready = 1'b1;
    send_word(32'h0000_0013);
    send_word(32'h00A0_0093);
    repeat (3) step();
    nvec++; if (mon_instr.size() != 2) begin nfail++; $display("FAIL aligned_count got %0d want 2", mon_instr.size()); end
    for (int i = 0; i < 2; i++) begin
      nvec++;
      if (i >= mon_instr.size() || mon_instr[i] !== ei[i] || mon_pc[i] !== ep[i] || mon_c[i] !== 1'b0) begin
        nfail++;
        $display("FAIL aligned_out[%0d] got %h@%h c=%b want %h@%h c=0", i,
                 (i < mon_instr.size()) ? mon_instr[i] : 32'hx, (i < mon_pc.size()) ? mon_pc[i] : 32'hx,
                 (i < mon_c.size()) ? mon_c[i] : 1'bx, ei[i], ep[i]);
      end
    end
  endtask

  task automatic test_compressed();
    logic [31:0] ei [2] = '{32'h0000_4581, 32'h0000_4501};
    logic [31:0] ep [2] = '{32'h0, 32'h2};
    do_reset();
    out_ready = 1'b1;
    send_word(32'h4501_4581);
    repeat (3) step();
    nvec++; if (mon_instr.size() != 2) begin nfail++; $display("FAIL packed_count got %0d want 2", mon_instr.size()); end
    for (int i = 0; i < 2; i++) begin
      nvec++;
      if (i >= mon_instr.size() || mon_instr[i] !== ei[i] || mon_pc[i] !== ep[i] || mon_c[i] !== 1'b1) begin
        nfail++;
        $display("FAIL packed_out[%0d] got %h@%h want %h@%h c=1", i,
                 (i < mon_instr.size()) ? mon_instr[i] : 32'hx, (i < mon_pc.size()) ? mon_pc[i] : 32'hx, ei[i], ep[i]);
      end
    end
  endtask

  task automatic test_straddle();
    logic [31:0] ei [3] = '{32'h0000_4501, 32'h0000_0013, 32'h0000_4501};
    logic [31:0] ep [3] = '{32'h0, 32'h2, 32'h6};
    logic        ec [3] = '{1'b1, 1'b0, 1'b1};
    do_reset();
    out_ready = 1'b1;
    send_word(32'h0013_4501);
    send_word(32'h4501_0000);
    repeat (4) step();
    nvec++; if (mon_instr.size() != 3) begin nfail++; $display("FAIL straddle_count got %0d want 3", mon_instr.size()); end
    for (int i = 0; i < 3; i++) begin
      nvec++;
      if (i >= mon_instr.size() || mon_instr[i] !== ei[i] || mon_pc[i] !== ep[i] || mon_c[i] !== ec[i]) begin
        nfail++;
        $display("FAIL straddle_out[%0d] got %h@%h want %h@%h c=%b", i,
                 (i < mon_instr.size()) ? mon_instr[i] : 32'hx, (i < mon_pc.size()) ? mon_pc[i] : 32'hx,
                 ei[i], ep[i], ec[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] ei [4] = '{32'h0000_4581, 32'h0000_4501, 32'h0000_4581, 32'h0000_4501};
    logic [31:0] ep [4] = '{32'h0, 32'h2, 32'h4, 32'h6};
    do_reset();
    out_ready = 1'b0;
    send_word(32'h4501_4581);
    send_word(32'h4501_4581);
    nvec++; if (in_ready !== 1'b0) begin nfail++; $display("FAIL bp_full_ready got %b want 0", in_ready); end
    nvec++; if (out_valid !== 1'b1 || out_instr !== 32'h0000_4581 || out_is_compressed !== 1'b1) begin
      nfail++; $display("FAIL bp_head got v=%b %h c=%b want v=1 00004581 c=1", out_valid, out_instr, out_is_compressed);
    end
    in_valid = 1'b1;
    in_data  = 32'hDEAD_BEEF;
    step();
    step();
    in_valid = 1'b0;
    nvec++; if (out_instr !== 32'h0000_4581 || out_pc !== 32'h0) begin
      nfail++; $display("FAIL bp_stable got %h@%h want 00004581@00000000", out_instr, out_pc);
    end
    out_ready = 1'b1;
    repeat (6) step();
    nvec++; if (mon_instr.size() != 4) begin nfail++; $display("FAIL bp_count got %0d want 4", mon_instr.size()); end
    for (int i = 0; i < 4; i++) begin
      nvec++;
      if (i >= mon_instr.size() || mon_instr[i] !== ei[i] || mon_pc[i] !== ep[i]) begin
        nfail++;
        $display("FAIL bp_out[%0d] got %h@%h want %h@%h", i,
                 (i < mon_instr.size()) ? mon_instr[i] : 32'hx, (i < mon_pc.size()) ? mon_pc[i] : 32'hx, ei[i], ep[i]);
      end
    end
  endtask

  task automatic test_flush();
    do_reset();
    out_ready = 1'b0;
    send_word(32'h4501_4581);
    flush     = 1'b1;
    flush_pc  = 32'h0000_0102;
    in_valid  = 1'b1;
    in_data   = 32'h00A0_0093;
    out_ready = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    nvec++; if (out_valid !== 1'b0) begin nfail++; $display("FAIL flush_valid got %b want 0", out_valid); end
    nvec++; if (out_pc !== 32'h0000_0102) begin nfail++; $display("FAIL flush_pc got %h want 00000102", out_pc); end
    nvec++; if (in_ready !== 1'b1) begin nfail++; $display("FAIL flush_in_ready got %b want 1", in_ready); end
    send_word(32'h4501_4581);
    repeat (3) step();
    nvec++; if (mon_instr.size() != 1) begin nfail++; $display("FAIL flush_count got %0d want 1", mon_instr.size()); end
    nvec++;
    if (mon_instr.size() < 1 || mon_instr[0] !== 32'h0000_4501 || mon_pc[0] !== 32'h102 || mon_c[0] !== 1'b1) begin
      nfail++;
      $display("FAIL flush_out got %h@%h want 00004501@00000102 c=1",
               (mon_instr.size() > 0) ? mon_instr[0] : 32'hx, (mon_pc.size() > 0) ? mon_pc[0] : 32'hx);
    end
    nvec++; if (out_valid !== 1'b0 || out_pc !== 32'h0000_0104) begin
      nfail++; $display("FAIL flush_after got v=%b pc=%h want v=0 pc=00000104", out_valid, out_pc);
    end
    // Reset pulse mid-cycle while the queue holds an instruction.
    out_ready = 1'b0;
    send_word(32'h0013_4501);
    nvec++; if (out_valid !== 1'b1) begin nfail++; $display("FAIL midrst_pre got %b want 1", out_valid); end
    #2;
    reset = 1'b0;
    #1;
    nvec++; if (out_valid !== 1'b0 || out_pc !== 32'h0) begin
      nfail++; $display("FAIL midrst_async got v=%b pc=%h want v=0 pc=00000000", out_valid, out_pc);
    end
    step();
    reset = 1'b1;
    step();
    clear_mon();
    out_ready = 1'b1;
    send_word(32'h4501_4581);
    repeat (3) step();
    nvec++;
    if (mon_instr.size() != 2 || mon_instr[0] !== 32'h0000_4581 || mon_pc[0] !== 32'h0) begin
      nfail++;
      $display("FAIL midrst_restart got n=%0d first=%h want n=2 first=00004581@00000000", mon_instr.size(),
               (mon_instr.size() > 0) ? mon_instr[0] : 32'hx);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    flush    = 1'b1;
    flush_pc = 32'hFFFF_FFFF;
    step();
    flush = 1'b0;
    nvec++; if (out_pc !== 32'hFFFF_FFFE) begin nfail++; $display("FAIL wrap_flush_pc got %h want fffffffe", out_pc); end
    out_ready = 1'b1;
    send_word(32'h4501_4581);
    repeat (3) step();
    nvec++;
    if (mon_instr.size() != 1 || mon_instr[0] !== 32'h0000_4501 || mon_pc[0] !== 32'hFFFF_FFFE) begin
      nfail++;
      $display("FAIL wrap_out got n=%0d %h@%h want n=1 00004501@fffffffe", mon_instr.size(),
               (mon_instr.size() > 0) ? mon_instr[0] : 32'hx, (mon_pc.size() > 0) ? mon_pc[0] : 32'hx);
    end
    nvec++; if (out_pc !== 32'h0) begin nfail++; $display("FAIL wrap_pc got %h want 00000000", out_pc); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w  [3] = '{32'h0000_0013, 32'h00A0_0093, 32'h0010_0113};
    logic [31:0] ep [3] = '{32'h0, 32'h4, 32'h8};
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = w[i];
      nvec++; if (in_ready !== 1'b1) begin nfail++; $display("FAIL b2b_ready[%0d] got %b want 1", i, in_ready); end
      step();
    end
    in_valid = 1'b0;
    repeat (3) step();
    nvec++; if (mon_instr.size() != 3) begin nfail++; $display("FAIL b2b_count got %0d want 3", mon_instr.size()); end
    for (int i = 0; i < 3; i++) begin
      nvec++;
      if (i >= mon_instr.size() || mon_instr[i] !== w[i] || mon_pc[i] !== ep[i]) begin
        nfail++;
        $display("FAIL b2b_out[%0d] got %h@%h want %h@%h", i,
                 (i < mon_instr.size()) ? mon_instr[i] : 32'hx, (i < mon_pc.size()) ? mon_pc[i] : 32'hx, w[i], ep[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_aligned();
    test_compressed();
    test_straddle();
    test_backpressure();
    test_flush();
    test_wrap();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
